// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic {IDLE, RUN} clk_div_state_e;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_odd_merge.sv
// Half-cycle stretch for odd divisors: the only negedge flop in the divider.
module clk_div_odd_merge (
  input  logic clk,
  input  logic rst,
  input  logic t1,
  input  logic odd,
  output logic clk_out
);

  logic t2;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) t2 <= 1'b0;
    else     t2 <= t1;
  end

  // t2 trails t1 by half a clk, so for odd N the high phase gains exactly half a cycle.
  assign clk_out = t1 | (t2 & odd);

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty integer clock divider with boundary-aligned divisor updates.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_i,
  input  logic         div_valid,
  output logic         div_ready,
  output logic         div_err,
  output logic [W-1:0] cur_div,
  output logic         clk_out,
  output logic         tick
);

  localparam logic [W-1:0] MIN_DIV_W = W'(MIN_DIV);
  localparam logic [W-1:0] RESET_DIV = W'(DEFAULT_DIV);
  localparam logic [W-1:0] ONE       = W'(1);

  clk_div_state_e state;
  logic [W-1:0]   cnt;
  logic [W-1:0]   next_cnt;
  logic [W-1:0]   next_half;
  logic [W-1:0]   pend;
  logic           pend_vld;
  logic           t1;
  logic           xfer;
  logic           boundary;

  assign div_ready = ~pend_vld;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    xfer      = div_valid && div_ready;
    boundary  = (state == RUN) && (cnt == cur_div - ONE);
    next_cnt  = boundary ? '0 : cnt + ONE;
    // A divisor swapped in at this boundary already shapes the next high phase.
    next_half = ((boundary && pend_vld) ? pend : cur_div) >> 1;
  end

  // NOTE: pend is payload qualified by pend_vld, so it carries no reset.
  always_ff @(posedge clk) begin
    if (xfer && (div_i >= MIN_DIV_W)) pend <= div_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      t1       <= 1'b0;
      cur_div  <= RESET_DIV;
      pend_vld <= 1'b0;
      div_err  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      div_err <= xfer && (div_i < MIN_DIV_W);
      if (xfer && (div_i >= MIN_DIV_W)) pend_vld <= 1'b1;

      case (state)
        IDLE: begin
          tick <= 1'b0;
          if (pend_vld) begin
            cur_div  <= pend;
            pend_vld <= 1'b0;
          end
          if (en) begin
            state <= RUN;
            cnt   <= '0;
            t1    <= 1'b1;
            tick  <= 1'b1;
          end
        end
        RUN: begin
          cnt <= next_cnt;
          if (boundary && pend_vld) begin
            cur_div  <= pend;
            pend_vld <= 1'b0;
          end
          // Parking only happens at a boundary, so the running period always completes.
          if (boundary && !en) begin
            state <= IDLE;
            t1    <= 1'b0;
            tick  <= 1'b0;
          end else begin
            t1   <= (next_cnt < next_half);
            tick <= (next_cnt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  clk_div_odd_merge u_odd_merge (
    .clk     (clk),
    .rst     (rst),
    .t1      (t1),
    .odd     (cur_div[0]),
    .clk_out (clk_out)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a vector table for steady running and error handling,
// then hand-written sequences for divisor updates, parking, max divisor and async reset.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div_i = '0;
  logic       div_valid = 1'b0;
  logic       div_ready, div_err, clk_out, tick;
  logic [7:0] cur_div;

  logic       rst4 = 1'b0;
  logic       en4 = 1'b0;
  logic [3:0] div_i4 = '0;
  logic       div_valid4 = 1'b0;
  logic       div_ready4, div_err4, clk_out4, tick4;
  logic [3:0] cur_div4;

  int n_tests = 0;
  int n_fail  = 0;

  clk_div_prog #(.W(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .div_i(div_i), .div_valid(div_valid),
    .div_ready(div_ready), .div_err(div_err), .cur_div(cur_div),
    .clk_out(clk_out), .tick(tick)
  );

  clk_div_prog #(.W(4), .DEFAULT_DIV(4)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .div_i(div_i4), .div_valid(div_valid4),
    .div_ready(div_ready4), .div_err(div_err4), .cur_div(cur_div4),
    .clk_out(clk_out4), .tick(tick4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       vld;
    logic [7:0] din;
    logic       exp_clk;
    logic       exp_tick;
    logic       exp_rdy;
    logic       exp_err;
    logic [7:0] exp_div;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int get_clk(input int sel);
    return (sel != 0) ? int'(clk_out4) : int'(clk_out);
  endfunction

  function automatic int get_tick(input int sel);
    return (sel != 0) ? int'(tick4) : int'(tick);
  endfunction

  function automatic int get_rdy(input int sel);
    return (sel != 0) ? int'(div_ready4) : int'(div_ready);
  endfunction

  // Steps until tick, returning the cycle count (-1 on timeout) and cycles with ready high.
  task automatic wait_tick(input int sel, input int budget, output int cycles, output int rdy_hi);
    bit done;
    done   = 1'b0;
    cycles = 0;
    rdy_hi = 0;
    while (!done && cycles < budget) begin
      step();
      cycles++;
      if (get_tick(sel) != 0) done = 1'b1;
      else if (get_rdy(sel) != 0) rdy_hi++;
    end
    if (!done) cycles = -1;
  endtask

  // Starting just after a tick, counts clk cycles and high half-cycles up to the next tick.
  task automatic measure(input int sel, input int exp_period, input int exp_hi, input string name);
    int  hi, cyc;
    bit  done;
    hi   = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      hi += get_clk(sel);
      @(negedge clk); #1;
      hi += get_clk(sel);
      step();
      cyc++;
      if (get_tick(sel) != 0) done = 1'b1;
    end
    check({name, "_period"}, cyc, exp_period);
    check({name, "_high_halves"}, hi, exp_hi);
    check({name, "_rise_with_tick"}, get_clk(sel), 1);
  endtask

  task automatic sample_cycles(input int n, output int hi, output int tk);
    hi = 0;
    tk = 0;
    for (int i = 0; i < n; i++) begin
      hi += int'(clk_out);
      @(negedge clk); #1;
      hi += int'(clk_out);
      step();
      tk += int'(tick);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc, rdy_hi, hi, tk;

    //                en    vld   din    clk   tick  rdy   err   div
    vecs[0]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4};
    vecs[1]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4};
    vecs[2]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4};
    vecs[3]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4};
    vecs[4]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4};
    vecs[5]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4};
    vecs[6]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4};
    vecs[7]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4};
    vecs[8]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4};
    vecs[9]  = '{1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd4};
    vecs[10] = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd4};
    vecs[11] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4};
    vecs[12] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4};

    // Reset state
    #1 rst = 1'b1; rst4 = 1'b1;
    #1;
    check("rst_clk_out", clk_out, 0);
    check("rst_tick", tick, 0);
    check("rst_ready", div_ready, 1);
    check("rst_err", div_err, 0);
    check("rst_cur_div", cur_div, 4);
    @(posedge clk); #1;
    rst = 1'b0; rst4 = 1'b0;

    // Default divisor 4, then rejected divisors 1 and 0 while running
    for (int i = 0; i < 13; i++) begin
      en        = vecs[i].en;
      div_valid = vecs[i].vld;
      div_i     = vecs[i].din;
      step();
      check($sformatf("vec%0d_clk_out", i), clk_out, vecs[i].exp_clk);
      check($sformatf("vec%0d_tick", i), tick, vecs[i].exp_tick);
      check($sformatf("vec%0d_ready", i), div_ready, vecs[i].exp_rdy);
      check($sformatf("vec%0d_err", i), div_err, vecs[i].exp_err);
      check($sformatf("vec%0d_cur_div", i), cur_div, vecs[i].exp_div);
    end

    // Update to 5 mid-period: current period stays 4, then 5-cycle periods with 2.5 high
    div_valid = 1'b1; div_i = 8'd5;
    step();
    div_valid = 1'b0;
    check("n5_pending_ready", div_ready, 0);
    check("n5_pending_cur_div", cur_div, 4);
    wait_tick(0, 20, cyc, rdy_hi);
    check("n5_old_period_rest", cyc, 3);
    check("n5_applied_cur_div", cur_div, 5);
    check("n5_applied_ready", div_ready, 1);
    measure(0, 5, 5, "n5_a");
    measure(0, 5, 5, "n5_b");

    // Back-to-back 7 then 3 with valid held
    div_valid = 1'b1; div_i = 8'd7;
    step();
    check("b2b_first_ready", div_ready, 0);
    div_i = 8'd3;
    wait_tick(0, 20, cyc, rdy_hi);
    check("b2b_n5_period_rest", cyc, 4);
    check("b2b_ready_low_while_pending", rdy_hi, 0);
    check("b2b_7_applied", cur_div, 7);
    check("b2b_ready_after_apply", div_ready, 1);
    step();
    div_valid = 1'b0;
    check("b2b_second_pending_ready", div_ready, 0);
    check("b2b_second_pending_cur_div", cur_div, 7);
    wait_tick(0, 20, cyc, rdy_hi);
    check("b2b_n7_period_rest", cyc, 6);
    check("b2b_3_applied", cur_div, 3);
    measure(0, 3, 3, "n3");

    // N=6, drop en mid-period: period completes, clk_out parks low, no further tick
    div_valid = 1'b1; div_i = 8'd6;
    step();
    div_valid = 1'b0;
    wait_tick(0, 20, cyc, rdy_hi);
    check("n6_n3_period_rest", cyc, 2);
    check("n6_applied_cur_div", cur_div, 6);
    step();
    en = 1'b0;
    sample_cycles(5, hi, tk);
    check("park_rest_high_halves", hi, 4);
    check("park_rest_ticks", tk, 0);
    check("park_clk_out_low", clk_out, 0);
    sample_cycles(10, hi, tk);
    check("parked_high_halves", hi, 0);
    check("parked_ticks", tk, 0);
    en = 1'b1;
    step();
    check("restart_tick", tick, 1);
    check("restart_clk_out", clk_out, 1);
    measure(0, 6, 6, "n6_restart");

    // W=4: max divisor 15 programmed while idle, then async reset mid-high
    div_valid4 = 1'b1; div_i4 = 4'd15;
    step();
    div_valid4 = 1'b0;
    step();
    check("w4_idle_apply_cur_div", cur_div4, 15);
    check("w4_idle_apply_ready", div_ready4, 1);
    en4 = 1'b1;
    step();
    check("w4_start_tick", tick4, 1);
    check("w4_start_clk_out", clk_out4, 1);
    measure(1, 15, 15, "n15");
    step();
    step();
    check("w4_mid_high", clk_out4, 1);
    #2 rst4 = 1'b1;
    #1;
    check("w4_rst_clk_out", clk_out4, 0);
    check("w4_rst_cur_div", cur_div4, 4);
    check("w4_rst_tick", tick4, 0);
    check("w4_rst_ready", div_ready4, 1);
    @(negedge clk); #1;
    check("w4_rst_clk_out_negedge", clk_out4, 0);
    rst4 = 1'b0;
    en4  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
